// File: rtl/poly_reduce_ctrl.sv
// poly_reduce_ctrl: walks all N coefficients of a polynomial out of RAM, through the
// single-cycle Barrett reducer and back into the same addresses. The three stages
// (read issue, reducer load, write-back) are tracked by two valid bits plus address
// copies. The pipeline never stalls; hold only inserts bubbles at the read stage.
module poly_reduce_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          hold,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          red_set,
    output logic [DW-1:0] red_a,
    input  logic [DW-1:0] red_t,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    // One extra bit so that reaching N (a wrap of the address bits) is visible.
    logic [AW:0]   issue_cnt_q, issue_cnt_d;
    logic          s1_valid_q, s1_valid_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic          s2_valid_q, s2_valid_d;
    logic [AW-1:0] s2_addr_q, s2_addr_d;
    logic          issue;
    logic          active;

    // Read issue happens in RUN whenever the read port is not lent out.
    always_comb begin
        active = (state_q == RUN) || (state_q == DRAIN);
        issue  = (state_q == RUN) && !hold;
    end

    // Next-state, counter and pipeline-advance logic.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        s1_valid_d  = issue;
        s1_addr_d   = issue_cnt_q[AW-1:0];
        s2_valid_d  = s1_valid_q;
        s2_addr_d   = s1_addr_q;

        if (issue) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = RUN;
                    issue_cnt_d = '0;
                end
            end
            RUN: begin
                // Leave RUN on the edge that issues the last read, so DRAIN starts
                // with that read in stage1 and no idle RUN cycle is inserted.
                if (issue_cnt_d[AW]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // stage1 can only empty here; once it is empty stage2 drains this cycle.
                if (!s1_valid_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && active) begin
            state_d     = IDLE;
            issue_cnt_d = '0;
            s1_valid_d  = 1'b0;
            s2_valid_d  = 1'b0;
        end
    end

    // State, counter and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s2_valid_q  <= s2_valid_d;
            s2_addr_q   <= s2_addr_d;
        end
    end

    // Output decode. Data buses are zeroed when their stage is empty.
    always_comb begin
        busy    = active;
        done    = (state_q == FIN);
        rd_en   = issue;
        rd_addr = issue_cnt_q[AW-1:0];
        red_set = s1_valid_q;
        red_a   = s1_valid_q ? rd_data : '0;
        // A write still in stage2 during the abort cycle is dropped, so an aborted
        // run leaves only the addresses whose write-back finished before the abort.
        wr_en   = s2_valid_q && !abort;
        wr_addr = s2_addr_q;
        wr_data = s2_valid_q ? red_t : '0;
    end

endmodule

// File: tb/tb_poly_reduce_ctrl.sv
// Testbench for poly_reduce_ctrl: behavioural RAM and Barrett reducer around the DUT,
// per-cycle expectations from a schedule model, and final RAM contents compared with
// the centred residue a mod 3329.
module tb_poly_reduce_ctrl;

    localparam int N  = 256;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int Q  = 3329;
    localparam int MAXC = 420;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 hold = 1'b0;
    logic                 abort = 1'b0;
    logic                 busy, done, rd_en, red_set, wr_en;
    logic [AW-1:0]        rd_addr, wr_addr;
    logic signed [DW-1:0] rd_data = '0;
    logic signed [DW-1:0] red_t = '0;
    logic [DW-1:0]        red_a, wr_data;

    logic signed [DW-1:0] ram [N];
    logic signed [DW-1:0] load_buf [N];
    logic signed [DW-1:0] snap [N];
    bit                   written_m [N];
    logic                 ld_all = 1'b0;

    int checks = 0;
    int errors = 0;

    poly_reduce_ctrl #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .red_set(red_set), .red_a(red_a), .red_t(red_t),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DW-1:0] barrett(input logic signed [DW-1:0] a);
        int ai, t;
        ai = int'(a);
        t  = (20159 * ai + 33554432) >>> 26;
        return 16'(ai - Q * t);
    endfunction

    function automatic int centred(input int a);
        int r;
        r = a % Q;
        if (r < 0) r += Q;
        if (r > Q / 2) r -= Q;
        return r;
    endfunction

    // Environment: RAM with 1-cycle read latency and the external reducer.
    always @(posedge clk) begin
        if (ld_all) begin
            for (int i = 0; i < N; i++) ram[i] <= load_buf[i];
        end else if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
        if (rd_en) rd_data <= ram[rd_addr];
        if (red_set) red_t <= barrett(red_a);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [DW-1:0] v);
        return {{16{v[DW-1]}}, v};
    endfunction

    task automatic load_ram();
        ld_all = 1'b1;
        @(posedge clk); #1;
        ld_all = 1'b0;
        for (int i = 0; i < N; i++) begin
            snap[i] = ram[i];
            written_m[i] = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_red_set"}, 32'(red_set), 0);
        chk({tag, "_red_a"}, 32'(red_a), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
    endtask

    // One run from a start at cycle 0. h0..h1: hold window, ab: abort cycle (0 none),
    // rc: cycle at which async reset is applied (0 none), s0/s1: stray start pulses.
    // Returns the observed done cycle and number of observed writes.
    task automatic run_case(input string tag, input int h0, input int h1, input int ab,
                            input int rc, input int s0, input int s1,
                            output int done_obs, output int wr_cnt);
        bit rd_e [MAXC + 1];
        int addr_e [MAXC + 1];
        int issued, last, end_c, nxt_wr;
        bit rs, we, by, dn, stop;
        issued = 0; last = 0; done_obs = -1; wr_cnt = 0; nxt_wr = 0; stop = 0;
        for (int c = 0; c <= MAXC; c++) begin
            rd_e[c] = 0; addr_e[c] = 0;
            if (c >= 1 && issued < N && !(c >= h0 && c <= h1) && !(ab != 0 && c > ab)) begin
                rd_e[c] = 1; addr_e[c] = issued; issued++; last = c;
            end
        end
        end_c = (ab != 0) ? ab + 5 : last + 6;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= end_c && !stop; c++) begin
            hold  = (c >= h0 && c <= h1);
            abort = (c == ab);
            start = (c == s0 || c == s1);
            @(negedge clk);
            rs = c >= 2 && rd_e[c-1] && !(ab != 0 && c > ab);
            we = c >= 3 && rd_e[c-2] && !(ab != 0 && c >= ab);
            by = (ab == 0 || c <= ab) && c <= last + 2;
            dn = (ab == 0) && c == last + 3;
            chk({tag, "_rd_en"}, 32'(rd_en), 32'(rd_e[c]));
            if (rd_e[c]) chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(addr_e[c]));
            chk({tag, "_red_set"}, 32'(red_set), 32'(rs));
            if (rs) chk({tag, "_red_a"}, sx(red_a), 32'(int'(snap[addr_e[c-1]])));
            chk({tag, "_wr_en"}, 32'(wr_en), 32'(we));
            if (we) begin
                chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(addr_e[c-2]));
                chk({tag, "_wr_order"}, 32'(wr_addr), 32'(nxt_wr));
                chk({tag, "_wr_data"}, sx(wr_data), 32'(centred(int'(snap[addr_e[c-2]]))));
                written_m[addr_e[c-2]] = 1'b1;
                nxt_wr++;
            end
            if (wr_en === 1'b1) wr_cnt++;
            if (done === 1'b1) done_obs = c;
            chk({tag, "_busy"}, 32'(busy), 32'(by));
            chk({tag, "_done"}, 32'(done), 32'(dn));
            if (c == rc) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero({tag, "_async_rst"});
                stop = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        hold = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    task automatic check_ram(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < N; i++) begin
            if (written_m[i]) begin
                if (int'(ram[i]) != centred(int'(snap[i]))) mism++;
                if (int'(ram[i]) < -1664 || int'(ram[i]) > 1664) mism++;
            end else if (ram[i] !== snap[i]) begin
                mism++;
            end
        end
        chk({tag, "_ram_contents"}, 32'(mism), 0);
    endtask

    initial begin
        int d_obs, w_obs;
        logic signed [DW-1:0] vals [6];
        vals[0] = 16'sd3329; vals[1] = 16'sd20000; vals[2] = -16'sd32768;
        vals[3] = 16'sd32767; vals[4] = 16'sd1664; vals[5] = 16'sd0;

        // Reset state.
        #2;
        check_outputs_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");
        @(posedge clk); #1;

        // Ramp data, no hold.
        for (int i = 0; i < N; i++) load_buf[i] = 16'(i * 131 - 16000);
        load_ram();
        run_case("ramp", 0, -1, 0, 0, 0, 0, d_obs, w_obs);
        chk("ramp_done_cycle", 32'(d_obs), 259);
        chk("ramp_write_count", 32'(w_obs), N);
        check_ram("ramp");

        // Boundary values at addresses 0..5, random elsewhere.
        for (int i = 0; i < N; i++) load_buf[i] = 16'($urandom);
        for (int i = 0; i < 6; i++) load_buf[i] = vals[i];
        load_ram();
        run_case("vals", 0, -1, 0, 0, 0, 0, d_obs, w_obs);
        chk("vals_0", sx(ram[0]), 0);
        chk("vals_1", sx(ram[1]), 26);
        chk("vals_2", sx(ram[2]), 522);
        chk("vals_3", sx(ram[3]), 32'(-523));
        chk("vals_4", sx(ram[4]), 1664);
        chk("vals_5", sx(ram[5]), 0);
        check_ram("vals");

        // Hold for cycles 10..19.
        for (int i = 0; i < N; i++) load_buf[i] = 16'($urandom);
        load_ram();
        run_case("hold", 10, 19, 0, 0, 0, 0, d_obs, w_obs);
        chk("hold_done_cycle", 32'(d_obs), 269);
        chk("hold_write_count", 32'(w_obs), N);
        check_ram("hold");

        // Abort at cycle 100, then a complete restart.
        for (int i = 0; i < N; i++) load_buf[i] = 16'($urandom);
        load_ram();
        run_case("abort", 0, -1, 100, 0, 0, 0, d_obs, w_obs);
        chk("abort_no_done", 32'(d_obs), 32'(-1));
        chk("abort_write_count", 32'(w_obs), 97);
        check_ram("abort");
        for (int i = 0; i < N; i++) begin
            snap[i] = ram[i];
            written_m[i] = 1'b0;
        end
        run_case("restart", 0, -1, 0, 0, 0, 0, d_obs, w_obs);
        chk("restart_done_cycle", 32'(d_obs), 259);
        check_ram("restart");

        // Stray starts while busy and during FIN, plus a random hold burst.
        for (int i = 0; i < N; i++) load_buf[i] = 16'($urandom);
        load_ram();
        begin
            int hs;
            hs = int'($urandom_range(5, 200));
            run_case("stray", hs, hs + 3, 0, 0, 50, 259 + 4, d_obs, w_obs);
            chk("stray_done_cycle", 32'(d_obs), 32'(263));
        end
        check_ram("stray");

        // start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("start_abort_busy", 32'(busy), 0);
            chk("start_abort_rd_en", 32'(rd_en), 0);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-run, then a normal run.
        for (int i = 0; i < N; i++) load_buf[i] = 16'($urandom);
        load_ram();
        run_case("rst", 0, -1, 0, 50, 0, 0, d_obs, w_obs);
        @(posedge clk); @(posedge clk); #1;
        check_outputs_zero("rst_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            snap[i] = ram[i];
            written_m[i] = 1'b0;
        end
        run_case("post_rst", 0, -1, 0, 0, 0, 0, d_obs, w_obs);
        chk("post_rst_done_cycle", 32'(d_obs), 259);
        check_ram("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
